// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing definitions: phase encodings, default 640x480 timing, phase sequencing helper.
// No logic of its own; imported by the axis counter and the top.
// Phase order is ACTIVE -> FP -> SYNC -> BP -> ACTIVE, skipping zero-length porches.
package vga_sync_gen_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // Default 640x480@60 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

  // Phase following 'cur'; porches of zero length are skipped entirely.
  function automatic phase_t next_phase(input phase_t cur, input int fp, input int bp);
    phase_t nxt;
    case (cur)
      PH_ACTIVE: nxt = (fp > 0) ? PH_FP : PH_SYNC;
      PH_FP:     nxt = PH_SYNC;
      PH_SYNC:   nxt = (bp > 0) ? PH_BP : PH_ACTIVE;
      default:   nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// State updates on the clk after i_adv; o_wrap is combinational (last position of the axis).
// No backpressure; only moves when i_adv is high.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CW     = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_adv,
  output logic [CW-1:0] o_cnt,
  output logic [1:0]    o_phase,
  output logic          o_wrap
);

  localparam int            TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);

  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [CW-1:0] r_pcnt, w_nxt_pcnt;   // count local to the current phase
  logic [CW-1:0] w_plast;              // last local count of the current phase
  phase_t        r_phase, w_nxt_phase;

  assign o_cnt   = r_cnt;
  assign o_phase = r_phase;
  assign o_wrap  = (r_cnt == LAST);

  // Last phase-local count for whichever phase is current
  always_comb begin
    w_plast = CW'(ACTIVE - 1);
    case (r_phase)
      PH_FP:   w_plast = CW'(FP - 1);
      PH_SYNC: w_plast = CW'(SYNC - 1);
      PH_BP:   w_plast = CW'(BP - 1);
      default: w_plast = CW'(ACTIVE - 1);
    endcase
  end

  // Next position and phase on an advance; hold otherwise
  always_comb begin
    w_nxt_cnt   = r_cnt;
    w_nxt_pcnt  = r_pcnt;
    w_nxt_phase = r_phase;
    if (i_adv) begin
      w_nxt_cnt = o_wrap ? '0 : r_cnt + 1'b1;
      if (r_pcnt == w_plast) begin
        w_nxt_pcnt  = '0;
        w_nxt_phase = next_phase(r_phase, FP, BP);
      end else begin
        w_nxt_pcnt = r_pcnt + 1'b1;
      end
    end
  end

  // Axis state register; reset parks at the first visible position
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_phase <= PH_ACTIVE;
    end else begin
      r_cnt   <= w_nxt_cnt;
      r_pcnt  <= w_nxt_pcnt;
      r_phase <= w_nxt_phase;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster generator: sync, display enable, masked coordinates, line/frame pulses.
// All outputs registered: they show the counter state of the previous clk (1-cycle latency).
// Never stalls; with VGA_SYNC_PIXCE_EN defined, i_pixCe gates every advance (levels hold, pulses last one clk).
// Reset release is expected to be synchronous to i_clk (synchronised upstream).
// H_TOTAL and V_TOTAL must fit in CW bits.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_reset,
`ifdef VGA_SYNC_PIXCE_EN
  input  logic          i_pixCe,
`endif
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_displayEn,
  output logic [CW-1:0] o_pixelX,
  output logic [CW-1:0] o_pixelY,
  output logic          o_lineStart,
  output logic          o_frameStart
);

  logic          w_ce;
  logic [CW-1:0] w_h_cnt, w_v_cnt;
  logic [1:0]    w_h_phase, w_v_phase;
  logic          w_h_wrap, w_v_wrap;
  logic          w_unused_v_wrap;
  logic          w_de;

`ifdef VGA_SYNC_PIXCE_EN
  assign w_ce = i_pixCe;
`else
  assign w_ce = 1'b1;
`endif

  // Frame wrap falls out of the vertical count itself; the flag is not needed here
  assign w_unused_v_wrap = w_v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_adv   (w_ce),
    .o_cnt   (w_h_cnt),
    .o_phase (w_h_phase),
    .o_wrap  (w_h_wrap)
  );

  // Vertical axis steps once per completed line, so vsync edges land on the h=0 advance
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_adv   (w_ce & w_h_wrap),
    .o_cnt   (w_v_cnt),
    .o_phase (w_v_phase),
    .o_wrap  (w_v_wrap)
  );

  assign w_de = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

  // Output registers: levels follow the current state on advance cycles, pulses are single-clk
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_hsync      <= ~SYNC_POL;
      o_vsync      <= ~SYNC_POL;
      o_displayEn  <= 1'b0;
      o_pixelX     <= '0;
      o_pixelY     <= '0;
      o_lineStart  <= 1'b0;
      o_frameStart <= 1'b0;
    end else begin
      o_lineStart  <= w_ce && (w_h_cnt == '0);
      o_frameStart <= w_ce && (w_h_cnt == '0) && (w_v_cnt == '0);
      if (w_ce) begin
        o_hsync     <= (w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        o_vsync     <= (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        o_displayEn <= w_de;
        o_pixelX    <= w_de ? w_h_cnt : '0;
        o_pixelY    <= w_de ? w_v_cnt : '0;
      end
    end
  end

endmodule
